// File: rtl/sdfm_pkg.sv
// Shared encodings, default widths and sizing helper for the multi-channel sigma-delta filter.
package sdfm_pkg;

  typedef enum logic [1:0] {
    ST_SINC1 = 2'b00,
    ST_SINC2 = 2'b01,
    ST_SINC3 = 2'b10
  } st_e;

  localparam int DEF_NCH    = 4;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEC_W  = 8;

  // Conservative limit: R^order stays below 2^(acc_w-1), so the comb never aliases.
  function automatic longint max_safe_dec(input int acc_w, input int order);
    int k;
    k = (order < 1) ? 1 : order;
    return (longint'(1) << ((acc_w - 1) / k)) - 1;
  endfunction

endpackage

// File: rtl/sdfm_sinc_chan.sv
// One channel: sinc1..3 integrators, decimation counter, comb, shifter and holding register.
// Sample reaches hold_vld two cycles after the terminal strobe; a full holding register that is not granted raises ovr_set.
module sdfm_sinc_chan
  import sdfm_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEC_W  = DEF_DEC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sd_dsd,
  input  logic              sd_clk,
  input  logic              en,
  input  logic [1:0]        st,
  input  logic [DEC_W-1:0]  dec,
  input  logic [4:0]        sh,
  input  logic              grant,
  output logic              hold_vld,
  output logic [DATA_W-1:0] hold_data,
  output logic              ovr_set
);

  logic [ACC_W-1:0] int1, int2, int3;
  logic [ACC_W-1:0] int1_nxt, int2_nxt, int3_nxt;
  logic [ACC_W-1:0] dly1, dly2, dly3;
  logic [ACC_W-1:0] comb1, comb2, comb3;
  logic [ACC_W-1:0] int_top, comb_out, shifted;
  logic [DATA_W-1:0] sample;
  logic [DEC_W-1:0] cnt;
  logic             fire;
  logic             strobe, terminal, use2, use3;

  assign use2     = (st != ST_SINC1);
  assign use3     = st[1];
  assign strobe   = en & sd_clk;
  assign terminal = (cnt == dec);

  // Cascade uses this strobe's updated value of the stage below.
  assign int1_nxt = int1 + ACC_W'(sd_dsd);
  assign int2_nxt = int2 + int1_nxt;
  assign int3_nxt = int3 + int2_nxt;

  assign int_top  = use3 ? int3 : (use2 ? int2 : int1);
  assign comb1    = int_top - dly1;
  assign comb2    = comb1 - dly2;
  assign comb3    = comb2 - dly3;
  assign comb_out = use3 ? comb3 : (use2 ? comb2 : comb1);
  assign shifted  = comb_out >> sh;

  generate
    if (DATA_W <= ACC_W) begin : g_trunc
      assign sample = shifted[DATA_W-1:0];
    end else begin : g_zext
      assign sample = {{(DATA_W - ACC_W){1'b0}}, shifted};
    end
  endgenerate

  assign ovr_set = en & fire & hold_vld & ~grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1      <= '0;
      int2      <= '0;
      int3      <= '0;
      dly1      <= '0;
      dly2      <= '0;
      dly3      <= '0;
      cnt       <= '0;
      fire      <= 1'b0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (!en) begin
      int1      <= '0;
      int2      <= '0;
      int3      <= '0;
      dly1      <= '0;
      dly2      <= '0;
      dly3      <= '0;
      cnt       <= '0;
      fire      <= 1'b0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else begin
      if (strobe) begin
        int1 <= int1_nxt;
        int2 <= use2 ? int2_nxt : '0;
        int3 <= use3 ? int3_nxt : '0;
        cnt  <= terminal ? '0 : cnt + DEC_W'(1);
      end
      fire <= strobe & terminal;

      // A fresh sample wins over a same-cycle grant, so the slot stays full.
      if (fire) begin
        dly1      <= int_top;
        dly2      <= use2 ? comb1 : '0;
        dly3      <= use3 ? comb2 : '0;
        hold_data <= sample;
        hold_vld  <= 1'b1;
      end else if (grant) begin
        hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdfm_mchan_filt.sv
// NCH sinc decimators merged onto one registered valid/ready stream by a round-robin arbiter; sticky per-channel overrun flags.
// First sample out three cycles after the terminal strobe; output holds while out_ready is low and channels overwrite their holding slot.
module sdfm_mchan_filt
  import sdfm_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEC_W  = DEF_DEC_W
) (
  input  logic                                      SYSCLK,
  input  logic                                      SYSRSTn,
  input  logic [NCH-1:0]                            sd_dsd_in,
  input  logic [NCH-1:0]                            sd_clk_in,
  input  logic [NCH-1:0]                            en,
  input  logic [2*NCH-1:0]                          st,
  input  logic [DEC_W*NCH-1:0]                      dec,
  input  logic [5*NCH-1:0]                          sh,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_W-1:0]                         out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  out_ch,
  output logic [NCH-1:0]                            ovr_flag,
  input  logic [NCH-1:0]                            ovr_clr
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]             hold_vld;
  logic [NCH-1:0][DATA_W-1:0] hold_data;
  logic [NCH-1:0]             ovr_set;
  logic [NCH-1:0]             grant;
  logic [CH_W-1:0]            last_grant;
  logic [CH_W-1:0]            gnt_idx;
  logic                       gnt_vld;
  logic                       can_load;
  int                         idx;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    sdfm_sinc_chan #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .DEC_W  (DEC_W)
    ) u_chan (
      .clk       (SYSCLK),
      .rst_n     (SYSRSTn),
      .sd_dsd    (sd_dsd_in[i]),
      .sd_clk    (sd_clk_in[i]),
      .en        (en[i]),
      .st        (st[2*i +: 2]),
      .dec       (dec[DEC_W*i +: DEC_W]),
      .sh        (sh[5*i +: 5]),
      .grant     (grant[i]),
      .hold_vld  (hold_vld[i]),
      .hold_data (hold_data[i]),
      .ovr_set   (ovr_set[i])
    );
  end

  assign can_load = !out_valid || out_ready;

  // Search starts one past the last winner; wraps so every channel is visited once.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_grant;
    grant   = '0;
    idx     = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_vld && hold_vld[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
    if (can_load && gnt_vld) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= CH_W'(NCH - 1);
    end else if (can_load) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data   <= hold_data[gnt_idx];
        out_ch     <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      ovr_flag <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ovr_set[i])      ovr_flag[i] <= 1'b1;
        else if (ovr_clr[i]) ovr_flag[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdfm_mchan_filt.sv
// Directed bench for sdfm_mchan_filt: hand-computed sinc outputs, arbitration order, overrun, stall, reset and enable behaviour.
module tb_sdfm_mchan_filt;

  logic        SYSCLK = 1'b0;
  logic        SYSRSTn;
  logic [3:0]  sd_dsd_in, sd_clk_in, en, ovr_clr, ovr_flag;
  logic [7:0]  st;
  logic [31:0] dec;
  logic [19:0] sh;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_ch;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q_data[$];
  logic [1:0]  q_ch[$];

  sdfm_mchan_filt dut (
    .SYSCLK    (SYSCLK),
    .SYSRSTn   (SYSRSTn),
    .sd_dsd_in (sd_dsd_in),
    .sd_clk_in (sd_clk_in),
    .en        (en),
    .st        (st),
    .dec       (dec),
    .sh        (sh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .ovr_flag  (ovr_flag),
    .ovr_clr   (ovr_clr)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Every accepted output beat is recorded for later in-order comparison.
  always @(negedge SYSCLK) begin
    if (SYSRSTn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      q_data.push_back(out_data);
      q_ch.push_back(out_ch);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge SYSCLK);
      #1;
    end
  endtask

  task automatic strobe(input logic [3:0] m, input logic [3:0] b);
    sd_clk_in = m;
    sd_dsd_in = b;
    tick(1);
    sd_clk_in = '0;
    sd_dsd_in = '0;
  endtask

  // Four consecutive strobes on the channels in m; pat gives the bit per strobe, MSB first.
  task automatic window(input logic [3:0] m, input logic [3:0] pat);
    for (int k = 0; k < 4; k++) strobe(m, pat[3-k] ? m : 4'b0000);
  endtask

  task automatic pop(input string tag, input logic [1:0] ch, input logic [31:0] d);
    logic [31:0] od;
    logic [1:0]  oc;
    chk({tag, "_present"}, 64'(q_data.size() != 0), 64'd1);
    if (q_data.size() != 0) begin
      od = q_data.pop_front();
      oc = q_ch.pop_front();
      chk({tag, "_ch"}, 64'(oc), 64'(ch));
      chk({tag, "_data"}, 64'(od), 64'(d));
    end
  endtask

  initial begin
    SYSRSTn   = 1'b0;
    sd_dsd_in = '0;
    sd_clk_in = '0;
    en        = '0;
    ovr_clr   = '0;
    st        = '0;
    dec       = '0;
    sh        = '0;
    out_ready = 1'b1;
    tick(2);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_ch",    64'(out_ch),    64'd0);
    chk("rst_ovr",   64'(ovr_flag),  64'd0);
    SYSRSTn = 1'b1;
    tick(1);

    // ch0 sinc1 R=4, constant 1, strobe every 4 cycles
    dec[7:0] = 8'd3;
    en = 4'b0001;
    tick(1);
    for (int s = 1; s <= 4; s++) begin
      strobe(4'b0001, 4'b0001);
      if (s < 4) tick(3);
    end
    tick(1);
    chk("a_t2_valid", 64'(out_valid), 64'd0);
    tick(1);
    chk("a_t3_valid", 64'(out_valid), 64'd1);
    chk("a_t3_data",  64'(out_data),  64'd4);
    chk("a_t3_ch",    64'(out_ch),    64'd0);
    tick(1);
    pop("a_s1", 2'd0, 32'd4);
    window(4'b0001, 4'hF);
    window(4'b0001, 4'hF);
    tick(4);
    pop("a_s2", 2'd0, 32'd4);
    pop("a_s3", 2'd0, 32'd4);
    en = 4'b0000;
    tick(1);

    // ch1 sinc3 R=4: constant 1, then sh=2, then alternating bits
    st[3:2]   = 2'b10;
    dec[15:8] = 8'd3;
    en = 4'b0010;
    for (int w = 0; w < 4; w++) window(4'b0010, 4'hF);
    tick(4);
    pop("b_s1", 2'd1, 32'd20);
    pop("b_s2", 2'd1, 32'd60);
    pop("b_s3", 2'd1, 32'd64);
    pop("b_s4", 2'd1, 32'd64);
    en = 4'b0000;
    sh[9:5] = 5'd2;
    tick(1);
    en = 4'b0010;
    for (int w = 0; w < 4; w++) window(4'b0010, 4'hF);
    tick(4);
    pop("b_sh1", 2'd1, 32'd5);
    pop("b_sh2", 2'd1, 32'd15);
    pop("b_sh3", 2'd1, 32'd16);
    pop("b_sh4", 2'd1, 32'd16);
    en = 4'b0000;
    sh[9:5] = 5'd0;
    tick(1);
    en = 4'b0010;
    for (int w = 0; w < 4; w++) window(4'b0010, 4'b1010);
    tick(4);
    pop("b_alt1", 2'd1, 32'd13);
    pop("b_alt2", 2'd1, 32'd31);
    pop("b_alt3", 2'd1, 32'd32);
    pop("b_alt4", 2'd1, 32'd32);
    en = 4'b0000;

    // all four channels, simultaneous terminal strobes, fresh arbiter pointer
    SYSRSTn = 1'b0;
    tick(1);
    SYSRSTn = 1'b1;
    st  = 8'h00;
    dec = 32'h0303_0303;
    sh  = '0;
    en  = 4'hF;
    tick(1);
    window(4'hF, 4'hF);
    tick(2);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("c_r1_valid%0d", c), 64'(out_valid), 64'd1);
      chk($sformatf("c_r1_ch%0d", c),    64'(out_ch),    64'(c));
      tick(1);
    end
    chk("c_r1_idle", 64'(out_valid), 64'd0);
    for (int c = 0; c < 4; c++) pop($sformatf("c_r1_s%0d", c), 2'(c), 32'd4);
    window(4'hF, 4'hF);
    tick(6);
    for (int c = 0; c < 4; c++) pop($sformatf("c_r2_s%0d", c), 2'(c), 32'd4);

    // ch2 overrun under a stall, then output stability
    en = 4'b0100;
    out_ready = 1'b0;
    window(4'b0100, 4'hF);
    window(4'b0100, 4'b1000);
    window(4'b0100, 4'b1100);
    tick(3);
    chk("d_ovr_set", 64'(ovr_flag), 64'd4);
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk($sformatf("d_stall%0d", c), {29'd0, out_valid, out_ch, out_data}, {29'd0, 1'b1, 2'd2, 32'd4});
    end
    out_ready = 1'b1;
    tick(3);
    pop("d_first", 2'd2, 32'd4);
    pop("d_newest", 2'd2, 32'd2);
    chk("d_lost_dropped", 64'(q_data.size()), 64'd0);
    ovr_clr = 4'b0100;
    tick(1);
    ovr_clr = 4'b0000;
    chk("d_ovr_clr", 64'(ovr_flag), 64'd0);

    // overrun set and clear in the same cycle
    out_ready = 1'b0;
    window(4'b0100, 4'b1110);
    window(4'b0100, 4'b1000);
    window(4'b0100, 4'hF);
    chk("d_pre_set", 64'(ovr_flag), 64'd0);
    ovr_clr = 4'b0100;
    tick(1);
    ovr_clr = 4'b0000;
    chk("d_set_wins", 64'(ovr_flag), 64'd4);
    out_ready = 1'b1;
    tick(3);
    pop("d_sw1", 2'd2, 32'd3);
    pop("d_sw2", 2'd2, 32'd4);
    ovr_clr = 4'b0100;
    tick(1);
    ovr_clr = 4'b0000;

    // new sample lands in the same cycle its channel is granted
    out_ready = 1'b0;
    window(4'b0100, 4'hF);
    window(4'b0100, 4'b1000);
    window(4'b0100, 4'b1100);
    out_ready = 1'b1;
    tick(4);
    chk("e_no_ovr", 64'(ovr_flag), 64'd0);
    pop("e_x", 2'd2, 32'd4);
    pop("e_y", 2'd2, 32'd1);
    pop("e_z", 2'd2, 32'd2);
    en = 4'b0000;
    tick(1);

    // asynchronous reset mid-decimation with an overrun pending
    en = 4'b0001;
    out_ready = 1'b0;
    tick(1);
    window(4'b0001, 4'hF);
    window(4'b0001, 4'hF);
    window(4'b0001, 4'hF);
    tick(2);
    chk("f_pre_ovr", 64'(ovr_flag), 64'd1);
    strobe(4'b0001, 4'b0001);
    strobe(4'b0001, 4'b0001);
    #1;
    SYSRSTn = 1'b0;
    #1;
    chk("f_rst_valid", 64'(out_valid), 64'd0);
    chk("f_rst_data",  64'(out_data),  64'd0);
    chk("f_rst_ovr",   64'(ovr_flag),  64'd0);
    tick(1);
    SYSRSTn = 1'b1;
    out_ready = 1'b1;
    tick(1);
    window(4'b0001, 4'hF);
    tick(2);
    chk("f_post_valid", 64'(out_valid), 64'd1);
    chk("f_post_data",  64'(out_data),  64'd4);
    tick(1);
    pop("f_post", 2'd0, 32'd4);

    // enable low clears the channel but not the output register
    out_ready = 1'b0;
    window(4'b0001, 4'hF);
    window(4'b0001, 4'b1000);
    strobe(4'b0001, 4'b0001);
    strobe(4'b0001, 4'b0001);
    en = 4'b0000;
    tick(1);
    chk("g_out_kept", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'd4});
    en = 4'b0001;
    out_ready = 1'b1;
    tick(3);
    pop("g_out", 2'd0, 32'd4);
    chk("g_hold_cleared", 64'(q_data.size()), 64'd0);
    window(4'b0001, 4'hF);
    tick(3);
    pop("g_fresh", 2'd0, 32'd4);
    chk("g_no_extra", 64'(q_data.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
